// File: rtl/disp_sched_pkg.sv
// Shared types and helpers for the display scheduler and its arbiter.
package disp_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    EOLS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] CHAR_CR = 8'h0d;
  localparam logic [7:0] CHAR_LF = 8'h0a;

  // Longest string a requester may supply; strings are zero-padded to this
  // width so that one extract function serves every NBYTES setting.
  localparam int MAX_BYTES    = 15;
  localparam int MAX_STR_BITS = MAX_BYTES * 8;

  // Byte k of a flattened string (byte 0 in the low bits, sent first).
  function automatic logic [7:0] get_byte(input logic [MAX_STR_BITS-1:0] s,
                                          input logic [3:0]              k);
    return s[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/disp_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] sel
);

  int   pos;
  logic found;

  // Scan ptr+1, ptr+2, ... modulo NREQ; the last-served requester is tried last.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    pos   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      pos = (int'(ptr) + off) % NREQ;
      if (!found && req[pos]) begin
        sel[pos] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_sched.sv
// Shares one serial display path between NREQ requesters: grants round-robin,
// captures the winner's string and streams it, then EOL, over valid/ready.
module disp_sched
  import disp_pkg::*;
#(
  parameter int         NREQ   = 4,
  parameter int         NBYTES = 7,
  parameter logic [7:0] EOL    = CHAR_CR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*NBYTES*8-1:0] str,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready
);

  localparam int SW = NBYTES * 8;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t            state_reg, state_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [IW-1:0]     idx_reg, idx_next, idx_inc;
  logic [SW-1:0]     buf_reg, buf_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              tx_valid_reg, tx_valid_next;

  logic [NREQ-1:0]   sel;
  logic [SW-1:0]     sel_str;
  logic [PW-1:0]     sel_idx;
  logic [SW-1:0]     str_field [NREQ];
  logic [MAX_STR_BITS-1:0] sel_pad, buf_pad;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (req),
    .ptr (ptr_reg),
    .sel (sel)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_field
    assign str_field[gi] = str[gi*SW +: SW];
  end

  // Turn the one-hot selection into the chosen string and its index.
  always_comb begin
    sel_str = '0;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        sel_str = str_field[i];
        sel_idx = PW'(i);
      end
    end
  end

  assign sel_pad = MAX_STR_BITS'(sel_str);
  assign buf_pad = MAX_STR_BITS'(buf_reg);
  assign idx_inc = idx_reg + 1'b1;

  // State and registered outputs; reset abandons any partial string.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= PW'(NREQ - 1);
      idx_reg      <= '0;
      buf_reg      <= '0;
      gnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      idx_reg      <= idx_next;
      buf_reg      <= buf_next;
      gnt_reg      <= gnt_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
    end
  end

  // Next-state logic: capture on grant, advance one byte per handshake.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    idx_next      = idx_reg;
    buf_next      = buf_reg;
    gnt_next      = '0;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    case (state_reg)
      IDLE: begin
        tx_valid_next = 1'b0;
        if (|req) begin
          buf_next      = sel_str;
          gnt_next      = sel;
          ptr_next      = sel_idx;
          busy_next     = 1'b1;
          idx_next      = '0;
          tx_valid_next = 1'b1;
          tx_data_next  = get_byte(sel_pad, 4'd0);
          state_next    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_reg == IW'(NBYTES - 1)) begin
            tx_data_next = EOL;
            state_next   = EOLS;
          end else begin
            idx_next     = idx_inc;
            tx_data_next = get_byte(buf_pad, 4'(idx_inc));
          end
        end
      end
      EOLS: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          busy_next     = 1'b0;
          done_next     = 1'b1;
          state_next    = DONE;
        end
      end
      DONE: begin
        // Mandatory gap cycle: no grant is issued while done is high.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt      = gnt_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with a byte scoreboard queue.
module tb_disp_sched;

  localparam int NREQ   = 4;
  localparam int NBYTES = 7;
  localparam int SW     = NBYTES * 8;
  localparam logic [7:0] EOL_B = 8'h0d;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*SW-1:0]   str;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 done;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sb_q [$];

  logic [SW-1:0] s0, s1, s2, s3, s0_cap;

  disp_sched #(.NREQ(NREQ), .NBYTES(NBYTES), .EOL(EOL_B)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .str      (str),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [SW-1:0] mk_str(input string s);
    logic [SW-1:0] v;
    v = '0;
    for (int k = 0; k < NBYTES; k++) v[k*8 +: 8] = s[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ":gnt"},      32'(gnt),      32'd0);
    chk({tag, ":busy"},     32'(busy),     32'd0);
    chk({tag, ":done"},     32'(done),     32'd0);
    chk({tag, ":tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, ":tx_data"},  32'(tx_data),  32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    sb_q.delete();
  endtask

  // Entered just after a negedge with req already driven. Waits for the grant,
  // queues the expected bytes, then checks every cycle until done and the gap.
  task automatic serve(input string tag, input logic [NREQ-1:0] exp_gnt,
                       input logic [SW-1:0] exp_str, input int max_wait,
                       input bit keep_req, input logic [NREQ-1:0] add_req,
                       input bit toggle_ready, input bit mutate);
    int cyc;
    int beats;
    int pat;
    logic rdy;
    @(negedge clk);
    cyc = 1;
    while (gnt === '0 && cyc < max_wait) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ":gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, ":busy_at_gnt"}, 32'(busy), 32'd1);
    for (int k = 0; k < NBYTES; k++) sb_q.push_back(exp_str[k*8 +: 8]);
    sb_q.push_back(EOL_B);
    if (!keep_req) req = req & ~exp_gnt;
    req   = req | add_req;
    beats = 0;
    pat   = 0;
    while (sb_q.size() > 0 && beats < 200) begin
      if (beats == 1) begin
        chk({tag, ":gnt_pulse"}, 32'(gnt), 32'd0);
        if (mutate) str[SW-1:0] = ~str[SW-1:0];
      end
      chk({tag, ":tx_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, ":busy"}, 32'(busy), 32'd1);
      chk({tag, ":tx_data"}, 32'(tx_data), 32'(sb_q[0]));
      rdy = toggle_ready ? (pat % 3 == 0) : 1'b1;
      pat++;
      tx_ready = rdy;
      if (rdy) void'(sb_q.pop_front());
      beats++;
      @(negedge clk);
    end
    if (!toggle_ready) chk({tag, ":beats"}, 32'(beats), 32'(NBYTES + 1));
    chk({tag, ":done"}, 32'(done), 32'd1);
    chk({tag, ":busy_end"}, 32'(busy), 32'd0);
    chk({tag, ":valid_end"}, 32'(tx_valid), 32'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk({tag, ":done_pulse"}, 32'(done), 32'd0);
    chk({tag, ":gap_gnt"}, 32'(gnt), 32'd0);
    $display("txn %s gnt=%b beats=%0d", tag, exp_gnt, beats);
  endtask

  initial begin
    s0 = mk_str("12:34AM");
    s1 = mk_str("ALM 07:");
    s2 = mk_str("STAT OK");
    s3 = mk_str("SNZ ON!");
    str      = {s3, s2, s1, s0};
    req      = '0;
    tx_ready = 1'b1;
    rst      = 1'b1;

    // Reset values, then idle hold with no requests.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle:tx_valid", 32'(tx_valid), 32'd0);
      chk("idle:gnt", 32'(gnt), 32'd0);
    end

    // Single request, continuous ready.
    req = 4'b0001;
    serve("t1", 4'b0001, s0, 1, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Requester 1 raises its request while requester 0 is being served.
    req = 4'b0001;
    serve("t6a", 4'b0001, s0, 1, 1'b0, 4'b0010, 1'b0, 1'b0);
    serve("t6b", 4'b0010, s1, 1, 1'b0, 4'b0000, 1'b0, 1'b0);

    // All requesting: rotation from a fresh pointer.
    do_reset();
    req = 4'b1111;
    serve("rr0", 4'b0001, s0, 1, 1'b1, 4'b0000, 1'b0, 1'b0);
    serve("rr1", 4'b0010, s1, 1, 1'b1, 4'b0000, 1'b0, 1'b0);
    serve("rr2", 4'b0100, s2, 1, 1'b1, 4'b0000, 1'b0, 1'b0);
    serve("rr3", 4'b1000, s3, 1, 1'b1, 4'b0000, 1'b0, 1'b0);
    serve("rr4", 4'b0001, s0, 1, 1'b1, 4'b0000, 1'b0, 1'b0);
    req = '0;

    // Backpressure: ready pattern 1,0,0 repeating.
    req = 4'b0100;
    serve("bp", 4'b0100, s2, 1, 1'b0, 4'b0000, 1'b1, 1'b0);

    // String changes one cycle after grant; captured value must be sent.
    s0_cap = str[SW-1:0];
    req = 4'b0001;
    serve("cap", 4'b0001, s0_cap, 1, 1'b0, 4'b0000, 1'b0, 1'b1);
    str[SW-1:0] = s0;

    // Reset during the third byte, then a new request after release.
    req = 4'b0001;
    @(negedge clk);
    chk("rmid:gnt", 32'(gnt), 32'b0001);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rmid:byte2", 32'(tx_data), 32'(s0[23:16]));
    #2 rst = 1'b1;
    #1 chk_zero_outputs("rmid_async");
    $display("txn rmid reset asserted mid-string");
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    req = 4'b0100;
    serve("rrel", 4'b0100, s2, 1, 1'b0, 4'b0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
